// File: rtl/piece_move_ctrl.sv
// Falling-piece sequencer: owns the live tetromino cells, runs gravity, arbitrates
// move requests and checks each candidate cell against the board before committing.
module piece_move_ctrl #(
  parameter int DROP_PERIOD = 50_000_000,
  parameter int TOP_ROW     = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       gen_flag,
  input  logic       q_move,
  input  logic [3:0] spawn_x1,
  input  logic [3:0] spawn_x2,
  input  logic [3:0] spawn_x3,
  input  logic [3:0] spawn_x4,
  input  logic [3:0] spawn_y1,
  input  logic [3:0] spawn_y2,
  input  logic [3:0] spawn_y3,
  input  logic [3:0] spawn_y4,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnD,
  input  logic [9:0] row_data,
  output logic [3:0] row_sel,
  output logic [3:0] x1,
  output logic [3:0] x2,
  output logic [3:0] x3,
  output logic [3:0] x4,
  output logic [3:0] y1,
  output logic [3:0] y2,
  output logic [3:0] y3,
  output logic [3:0] y4,
  output logic       bottom_flag,
  output logic       top_flag,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_CHECK = 2'd2, S_LOCK = 2'd3} state_t;
  typedef enum logic [1:0] {OP_L = 2'd0, OP_R = 2'd1, OP_D = 2'd2} op_t;

  localparam logic [25:0] DROP_LAST = 26'(DROP_PERIOD - 1);
  localparam logic [3:0]  TOP_ROW_C = 4'(TOP_ROW);

  state_t      state_r;
  op_t         op_r;
  op_t         op_sel_s;
  logic [1:0]  idx_r;
  logic [3:0]  x_r [4];
  logic [3:0]  y_r [4];
  logic [2:0]  pend_r;
  logic [2:0]  pend_set_s;
  logic [2:0]  pend_clr_s;
  logic [25:0] cnt_r;
  logic [3:0]  row_sel_r;
  logic        bottom_flag_r;
  logic        top_flag_r;
  logic        busy_r;
  logic [3:0]  cx_s;
  logic [3:0]  cy_s;
  logic        wall_s;
  logic        fail_s;
  logic        run_s;
  logic        grav_exp_s;
  logic        top_s;

  // Row holding the candidate cell: only a down move changes the row.
  function automatic logic [3:0] cand_row(input op_t op, input logic [3:0] y);
    if (op == OP_D) begin
      return y - 4'd1;
    end else begin
      return y;
    end
  endfunction

  assign run_s      = (state_r == S_WAIT) || (state_r == S_CHECK);
  assign grav_exp_s = run_s && (cnt_r == DROP_LAST);
  assign top_s      = (y_r[0] >= TOP_ROW_C) || (y_r[1] >= TOP_ROW_C) ||
                      (y_r[2] >= TOP_ROW_C) || (y_r[3] >= TOP_ROW_C);

  // Candidate cell for the current index and its pass/fail verdict.
  always_comb begin
    cx_s   = x_r[idx_r];
    cy_s   = y_r[idx_r];
    wall_s = 1'b0;
    case (op_r)
      OP_L: begin
        wall_s = (x_r[idx_r] == 4'd0);
        cx_s   = x_r[idx_r] - 4'd1;
      end
      OP_R: begin
        wall_s = (x_r[idx_r] == 4'd9);
        cx_s   = x_r[idx_r] + 4'd1;
      end
      OP_D: begin
        wall_s = (y_r[idx_r] == 4'd0);
        cy_s   = y_r[idx_r] - 4'd1;
      end
      default: wall_s = 1'b1;
    endcase
    if (wall_s) begin
      fail_s = 1'b1;
    end else if ((cy_s <= 4'd11) && (cx_s <= 4'd9)) begin
      fail_s = row_data[cx_s];
    end else begin
      fail_s = 1'b0;
    end
  end

  // Request arbitration (L > R > D) and pending-bit set/clear terms.
  always_comb begin
    if (pend_r[0]) begin
      op_sel_s = OP_L;
    end else if (pend_r[1]) begin
      op_sel_s = OP_R;
    end else begin
      op_sel_s = OP_D;
    end
    if (state_r != S_IDLE) begin
      pend_set_s = {BtnD | grav_exp_s, BtnR, BtnL};
    end else begin
      pend_set_s = 3'b000;
    end
    if (gen_flag || (state_r == S_LOCK)) begin
      pend_clr_s = 3'b111;
    end else if ((state_r == S_WAIT) && q_move && (|pend_r)) begin
      case (op_sel_s)
        OP_L:    pend_clr_s = 3'b001;
        OP_R:    pend_clr_s = 3'b010;
        default: pend_clr_s = 3'b100;
      endcase
    end else begin
      pend_clr_s = 3'b000;
    end
  end

  // Pending request bits; a set in the same cycle as a clear wins.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_r <= 3'b000;
    end else begin
      pend_r <= (pend_r & ~pend_clr_s) | pend_set_s;
    end
  end

  // Gravity timer, counting only while a piece is live and not locking.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_r <= 26'd0;
    end else if (gen_flag) begin
      cnt_r <= 26'd0;
    end else if (run_s) begin
      cnt_r <= grav_exp_s ? 26'd0 : cnt_r + 26'd1;
    end else begin
      cnt_r <= 26'd0;
    end
  end

  // Main sequencer with registered outputs.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r       <= S_IDLE;
      op_r          <= OP_L;
      idx_r         <= 2'd0;
      row_sel_r     <= 4'd0;
      bottom_flag_r <= 1'b0;
      top_flag_r    <= 1'b0;
      busy_r        <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        x_r[i] <= 4'd0;
        y_r[i] <= 4'd0;
      end
    end else begin
      bottom_flag_r <= 1'b0;
      top_flag_r    <= 1'b0;
      if (gen_flag) begin
        x_r[0]    <= spawn_x1;
        x_r[1]    <= spawn_x2;
        x_r[2]    <= spawn_x3;
        x_r[3]    <= spawn_x4;
        y_r[0]    <= spawn_y1;
        y_r[1]    <= spawn_y2;
        y_r[2]    <= spawn_y3;
        y_r[3]    <= spawn_y4;
        state_r   <= S_WAIT;
        busy_r    <= 1'b1;
        row_sel_r <= 4'd0;
      end else begin
        case (state_r)
          S_IDLE: begin
            busy_r    <= 1'b0;
            row_sel_r <= 4'd0;
          end
          S_WAIT: begin
            if (!q_move) begin
              state_r <= S_IDLE;
              busy_r  <= 1'b0;
            end else if (|pend_r) begin
              state_r   <= S_CHECK;
              op_r      <= op_sel_s;
              idx_r     <= 2'd0;
              row_sel_r <= cand_row(op_sel_s, y_r[0]);
            end else begin
              state_r <= S_WAIT;
            end
          end
          S_CHECK: begin
            if (!q_move) begin
              state_r   <= S_IDLE;
              busy_r    <= 1'b0;
              row_sel_r <= 4'd0;
            end else if (fail_s) begin
              row_sel_r <= 4'd0;
              if (op_r == OP_D) begin
                state_r       <= S_LOCK;
                busy_r        <= 1'b0;
                bottom_flag_r <= 1'b1;
                top_flag_r    <= top_s;
              end else begin
                state_r <= S_WAIT;
              end
            end else if (idx_r == 2'd3) begin
              state_r   <= S_WAIT;
              row_sel_r <= 4'd0;
              for (int i = 0; i < 4; i++) begin
                case (op_r)
                  OP_L:    x_r[i] <= x_r[i] - 4'd1;
                  OP_R:    x_r[i] <= x_r[i] + 4'd1;
                  OP_D:    y_r[i] <= y_r[i] - 4'd1;
                  default: x_r[i] <= x_r[i];
                endcase
              end
            end else begin
              idx_r     <= idx_r + 2'd1;
              row_sel_r <= cand_row(op_r, y_r[idx_r + 2'd1]);
            end
          end
          S_LOCK: begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
          end
          default: begin
            state_r   <= S_IDLE;
            busy_r    <= 1'b0;
            row_sel_r <= 4'd0;
          end
        endcase
      end
    end
  end

  assign x1          = x_r[0];
  assign x2          = x_r[1];
  assign x3          = x_r[2];
  assign x4          = x_r[3];
  assign y1          = y_r[0];
  assign y2          = y_r[1];
  assign y3          = y_r[2];
  assign y4          = y_r[3];
  assign row_sel     = row_sel_r;
  assign bottom_flag = bottom_flag_r;
  assign top_flag    = top_flag_r;
  assign busy        = busy_r;

endmodule

// File: doc/piece_move_ctrl.md
# piece_move_ctrl

Sequencer for the falling tetromino while the board controller is in MOVE. It owns the live piece coordinates and runs a gravity timer. It arbitrates gravity and player move requests, and checks each candidate move cell by cell against the board through a one-row read port. When a downward move is blocked, it issues the one-cycle lock pulse (bottom_flag, plus top_flag on overflow) that the board controller uses to stamp the piece and advance to CLEAR or LOST.

## Interface
- DROP_PERIOD, 50_000_000, gravity interval in Clk cycles (26-bit counter)
- TOP_ROW, 10, lock with any cell y >= TOP_ROW raises top_flag
- Board is fixed at 10 columns (x 0..9) and 12 rows (y 0..11); y=0 is the bottom row and higher y is higher on screen.

- Clk  in  1  clock
- Reset  in  1  reset Reset, asynchronous, active-high; clock Clk
- gen_flag  in  1  board controller is in BLOCKGEN; loads the spawn coordinates
- q_move  in  1  board controller is in MOVE
- spawn_x1..spawn_x4, spawn_y1..spawn_y4  in  4 each  new piece cells, valid with gen_flag
- BtnL, BtnR, BtnD  in  1 each  debounced single-cycle pulses: left, right, soft drop
- row_data  in  10  occupancy of row row_sel, combinational, bit i is column x=i
- row_sel  out  4  row address for the board read
- x1..x4, y1..y4  out  4 each  live piece cells, driven straight to the board controller
- bottom_flag  out  1  lock pulse
- top_flag  out  1  overflow pulse, asserted only together with bottom_flag
- busy  out  1  FSM is in WAIT or CHECK

## Operation
- States:
  - IDLE: no live piece.
  - WAIT: live piece, no move in progress.
  - CHECK: candidate move being tested, 4 cycles maximum, index idx 0..3.
  - LOCK: one cycle.
- Pending bits: pend_L, pend_R, pend_D.
  - A Btn pulse sets its bit in any state except IDLE.
  - A gravity expiry sets pend_D; BtnD also sets pend_D.
  - Simultaneous sources merge into one bit.
  - When set and clear hit the same bit in the same cycle, set wins.
- Gravity counter:
  - Runs in WAIT and CHECK.
  - At count DROP_PERIOD-1 it sets pend_D and wraps to 0.
  - Cleared by gen_flag and held at 0 in IDLE and LOCK.
- IDLE:
  - gen_flag loads the spawn coordinates into x/y, clears all pending bits and the counter, then goes to WAIT.
- WAIT:
  - With any pending bit, the FSM latches op by fixed priority L > R > D, clears that bit, sets idx=0 and goes to CHECK.
- CHECK, for cell idx:
  - Candidate: left is (x-1, y); right is (x+1, y); down is (x, y-1).
  - row_sel = candidate y.
  - The cell fails if any of these hold:
    - x=0 on left
    - x=9 on right
    - y=0 on down
    - candidate y <= 11 and row_data[candidate x]=1
  - A candidate y >= 12 is treated as empty; row_data is ignored.
  - On the first failing cell the check aborts: op D goes to LOCK; op L/R discards the move and returns to WAIT.
  - If idx=3 passes, all four cells take their candidate values on that edge and the FSM returns to WAIT.
- LOCK:
  - bottom_flag=1 for exactly this cycle, with x/y unchanged.
  - top_flag=1 in the same cycle if any y >= TOP_ROW.
  - Pending bits are cleared; next state is IDLE.
- gen_flag outside IDLE reloads the spawn and enters WAIT. This is a resync, not an error.
- If q_move is low in WAIT or CHECK, the FSM goes to IDLE with no lock pulse and x/y are held.
- row_sel = 0 outside CHECK.

## Timing
- Reset values:
  - state IDLE
  - x1..x4, y1..y4 = 0
  - row_sel = 0
  - bottom_flag = 0, top_flag = 0, busy = 0
  - pending bits and gravity counter = 0
- Request pulse at edge E0 sets its pending bit.
- E1: WAIT accepts the request into CHECK.
- A successful move updates the coordinates at E5, the 4th CHECK edge.
- A blocked cell aborts at the edge of its own CHECK cycle. The earliest abort is E2; for op D the following cycle is LOCK.
- Accepting a request takes 5 cycles minimum; DROP_PERIOD must be >= 6.
- bottom_flag/top_flag are registered Moore outputs, high for exactly one cycle. x/y stay stable through that cycle and until the next gen_flag.

## Test plan
- Gravity fall:
  - DROP_PERIOD=16, empty board, spawn O piece (4,11)(5,11)(4,10)(5,10).
  - Required: y decreases by 1 every 16 cycles.
  - Lock at (4,1)(5,1)(4,0)(5,0) with bottom_flag=1 for one cycle and top_flag=0.
- Left wall: piece with a cell at x=0, BtnL pulse -> no coordinate change, no lock, back in WAIT by the 2nd cycle after acceptance.
- Stack collision:
  - row_data = 10'h3FF for row_sel=0, 0 otherwise.
  - Required: the piece locks with lowest cells at y=1; bottom_flag pulses; coordinates are stable during the pulse.
- Top-out:
  - Row 9 full, spawn at rows 10/11.
  - Required: the first gravity check fails, then bottom_flag=1 and top_flag=1 in the same cycle, then IDLE.
- Arbitration:
  - BtnL, BtnR and BtnD pulsed in the same cycle, empty board.
  - Required: left executes, then right, then down. Net result: x unchanged, y-1, three separate CHECK sequences.
- Reset:
  - Assert Reset in the 2nd CHECK cycle.
  - Required: all outputs go to 0 asynchronously and the FSM goes to IDLE; the next gen_flag loads the spawn normally.
